// File: rtl/rv32i_types_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rv32i_types_pkg
// Description : Core-wide RV32I/M scalar types: the machine word and the
//               M-extension operation encoding (funct3 order).
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types_pkg;

    typedef logic [31:0] word_t;

    // Values follow the RV32M funct3 field so decode can cast directly.
    typedef enum logic [2:0] {
        M_MUL    = 3'd0,
        M_MULH   = 3'd1,
        M_MULHSU = 3'd2,
        M_MULHU  = 3'd3,
        M_DIV    = 3'd4,
        M_DIVU   = 3'd5,
        M_REM    = 3'd6,
        M_REMU   = 3'd7
    } rv32m_op_t;

endpackage
`default_nettype wire

// File: rtl/stage3_types_pkg.sv
`default_nettype none
// ============================================================================
// Package     : stage3_types_pkg
// Description : Execute-stage (stage 3) types for the M-extension sequencer:
//               sequencer state encoding and the single result-cache entry.
// Revision    : 1.0 - initial release
// ============================================================================
package stage3_types_pkg;

    import rv32i_types_pkg::*;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // accepting requests, answering cache hits
        RUN   = 2'd1,   // M unit computing the latched command
        DRAIN = 2'd2    // squashed op still in flight; result will be dropped
    } muldiv_seq_state_t;

    typedef struct packed {
        logic      valid;
        rv32m_op_t op;
        word_t     a;
        word_t     b;
        word_t     value;
    } muldiv_cache_entry_t;

endpackage
`default_nettype wire

// File: rtl/stage3_muldiv_result_cache.sv
`default_nettype none
// ============================================================================
// Module      : stage3_muldiv_result_cache
// Description : One-entry result cache for the M unit. Stores the last
//               completed {op, a, b, value} and flags a hit when the
//               presented request matches exactly.
// Ports       : CLK, RST            - clock, synchronous active-high reset
//               i_wr_en/op/a/b/value - write a completed result (sets valid)
//               i_lookup_valid/op/a/b - request to compare against the entry
//               o_hit, o_hit_value   - match flag and stored value
// Revision    : 1.0 - initial release
// ============================================================================
module stage3_muldiv_result_cache
    import rv32i_types_pkg::*;
    import stage3_types_pkg::*;
(
    input  logic      CLK,
    input  logic      RST,
    input  logic      i_wr_en,
    input  rv32m_op_t i_wr_op,
    input  word_t     i_wr_a,
    input  word_t     i_wr_b,
    input  word_t     i_wr_value,
    input  logic      i_lookup_valid,
    input  rv32m_op_t i_lookup_op,
    input  word_t     i_lookup_a,
    input  word_t     i_lookup_b,
    output logic      o_hit,
    output word_t     o_hit_value
);

    muldiv_cache_entry_t r_entry;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_entry <= '0;
        end else if (i_wr_en) begin
            r_entry <= '{valid: 1'b1, op: i_wr_op, a: i_wr_a,
                         b: i_wr_b, value: i_wr_value};
        end
    end

    assign o_hit = i_lookup_valid & r_entry.valid
                 & (r_entry.op == i_lookup_op)
                 & (r_entry.a  == i_lookup_a)
                 & (r_entry.b  == i_lookup_b);

    assign o_hit_value = r_entry.value;

endmodule
`default_nettype wire

// File: rtl/stage3_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : stage3_muldiv_sequencer
// Description : Execute-stage controller for the iterative M unit. A miss
//               launches the unit and holds the stage; completion fills a
//               one-entry cache and the held instruction then retires
//               through a cache hit. Squashed ops are drained, not aborted.
// Ports       : CLK, RST                 - clock, sync active-high reset
//               req_valid/op/a/b         - M-extension request from execute
//               stall, flush             - ex/mem not accepting / squash
//               busy                     - hold execute stage
//               result_valid, result     - completed value (0 when invalid)
//               fu_start/op/a/b          - command to the M unit
//               fu_done, fu_out          - M unit completion
//               hit_cnt, miss_cnt        - performance counters (wrapping)
// Revision    : 1.0 - initial release
// ============================================================================
module stage3_muldiv_sequencer
    import rv32i_types_pkg::*;
    import stage3_types_pkg::*;
(
    input  logic      CLK,
    input  logic      RST,
    input  logic      req_valid,
    input  rv32m_op_t req_op,
    input  word_t     req_a,
    input  word_t     req_b,
    input  logic      stall,
    input  logic      flush,
    output logic      busy,
    output logic      result_valid,
    output word_t     result,
    output logic      fu_start,
    output rv32m_op_t fu_op,
    output word_t     fu_a,
    output word_t     fu_b,
    input  logic      fu_done,
    input  word_t     fu_out,
    output word_t     hit_cnt,
    output word_t     miss_cnt
);

    muldiv_seq_state_t r_state;
    muldiv_seq_state_t w_state_next;
    rv32m_op_t         r_op;
    word_t             r_a;
    word_t             r_b;
    word_t             r_hit_cnt;
    word_t             r_miss_cnt;
    logic              r_rst_q;
    logic              w_quiet;
    logic              w_hit;
    word_t             w_hit_value;
    logic              w_cache_wr;
    logic              w_hit_retire;

    // Outputs stay silent during reset and for the cycle right after it, so
    // nothing is launched or retired off still-settling upstream state.
    assign w_quiet = RST | r_rst_q;

    always_ff @(posedge CLK) begin
        r_rst_q <= RST;
    end

    stage3_muldiv_result_cache u_cache (
        .CLK            (CLK),
        .RST            (RST),
        .i_wr_en        (w_cache_wr),
        .i_wr_op        (r_op),
        .i_wr_a         (r_a),
        .i_wr_b         (r_b),
        .i_wr_value     (fu_out),
        .i_lookup_valid (req_valid),
        .i_lookup_op    (req_op),
        .i_lookup_a     (req_a),
        .i_lookup_b     (req_b),
        .o_hit          (w_hit),
        .o_hit_value    (w_hit_value)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        result_valid = 1'b0;
        fu_start     = 1'b0;
        w_cache_wr   = 1'b0;
        if (!w_quiet) begin
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        result_valid = 1'b1;
                    end else if (req_valid && !flush) begin
                        fu_start     = 1'b1;
                        busy         = 1'b1;
                        w_state_next = RUN;
                    end
                end
                RUN: begin
                    busy = 1'b1;
                    if (flush) begin
                        // The unit cannot be aborted; wait out its done pulse
                        // unless it arrives right now.
                        w_state_next = fu_done ? IDLE : DRAIN;
                    end else if (fu_done) begin
                        w_cache_wr   = 1'b1;
                        w_state_next = IDLE;
                    end
                end
                DRAIN: begin
                    // Only a live successor needs holding while the unit
                    // finishes the squashed op.
                    busy = req_valid & ~flush;
                    if (fu_done) begin
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // Command registers capture the request on the launch cycle; the launch
    // cycle itself forwards the request so the unit sees it immediately.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_op <= M_MUL;
            r_a  <= '0;
            r_b  <= '0;
        end else if (fu_start) begin
            r_op <= req_op;
            r_a  <= req_a;
            r_b  <= req_b;
        end
    end

    assign fu_op  = fu_start ? req_op : r_op;
    assign fu_a   = fu_start ? req_a  : r_a;
    assign fu_b   = fu_start ? req_b  : r_b;
    assign result = result_valid ? w_hit_value : '0;

    // A hit retires only when the instruction actually leaves execute.
    assign w_hit_retire = result_valid & ~stall & ~flush;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit_retire) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (fu_start) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_stage3_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage3_muldiv_sequencer
// Description : Self-checking bench for stage3_muldiv_sequencer. Inputs are
//               driven 1 time unit after the rising edge and outputs sampled
//               on the falling edge. Expected results are queued when a
//               request is issued and popped when result_valid is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage3_muldiv_sequencer;

    import rv32i_types_pkg::*;

    logic      CLK = 1'b0;
    logic      RST;
    logic      req_valid;
    rv32m_op_t req_op;
    word_t     req_a;
    word_t     req_b;
    logic      stall;
    logic      flush;
    logic      busy;
    logic      result_valid;
    word_t     result;
    logic      fu_start;
    rv32m_op_t fu_op;
    word_t     fu_a;
    word_t     fu_b;
    logic      fu_done;
    word_t     fu_out;
    word_t     hit_cnt;
    word_t     miss_cnt;

    int        total = 0;
    int        bad   = 0;
    word_t     sb[$];
    word_t     exp_hit  = 0;
    word_t     exp_miss = 0;

    stage3_muldiv_sequencer dut (
        .CLK          (CLK),
        .RST          (RST),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .stall        (stall),
        .flush        (flush),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .fu_start     (fu_start),
        .fu_op        (fu_op),
        .fu_a         (fu_a),
        .fu_b         (fu_b),
        .fu_done      (fu_done),
        .fu_out       (fu_out),
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input logic v, input rv32m_op_t op, input word_t a, input word_t b);
        req_valid = v;
        req_op    = op;
        req_a     = a;
        req_b     = b;
    endtask

    task automatic test_reset();
        RST = 1'b1; stall = 1'b0; flush = 1'b0;
        set_req(1'b1, M_MUL, 32'd1, 32'd1);
        fu_done = 1'b1; fu_out = 32'd5;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            total++;
            if ({busy, result_valid, fu_start, result} !== {3'b000, 32'd0}) begin
                bad++;
                $display("FAIL reset_hold c%0d: got busy=%b rv=%b start=%b res=%h want all 0",
                         c, busy, result_valid, fu_start, result);
            end
            next_cycle();
        end
        RST = 1'b0;
        @(negedge CLK);
        total++;
        if ({busy, result_valid, fu_start, result} !== {3'b000, 32'd0}) begin
            bad++;
            $display("FAIL reset_after: got busy=%b rv=%b start=%b res=%h want all 0",
                     busy, result_valid, fu_start, result);
        end
        total++;
        if ({hit_cnt, miss_cnt} !== 64'd0) begin
            bad++;
            $display("FAIL reset_counters: got hit=%0d miss=%0d want 0 0", hit_cnt, miss_cnt);
        end
        next_cycle();
        req_valid = 1'b0; fu_done = 1'b0; fu_out = 32'd0;
        next_cycle();
    endtask

    // MUL 7*6, done 4 cycles after launch; result retires on cycle 5 under
    // stall so the hit counter stays at 0 here.
    task automatic test_mul_miss();
        word_t e;
        set_req(1'b1, M_MUL, 32'd7, 32'd6);
        sb.push_back(32'd42);
        for (int c = 0; c <= 5; c++) begin
            fu_done = (c == 4);
            fu_out  = (c == 4) ? 32'd42 : 32'hDEAD_BEEF;
            stall   = (c == 5);
            @(negedge CLK);
            if (c <= 4) begin
                total++;
                if ({busy, result_valid, fu_start} !== {1'b1, 1'b0, (c == 0)}) begin
                    bad++;
                    $display("FAIL mul_run c%0d: got busy=%b rv=%b start=%b want 1 0 %b",
                             c, busy, result_valid, fu_start, (c == 0));
                end
                total++;
                if ({fu_op, fu_a, fu_b} !== {M_MUL, 32'd7, 32'd6}) begin
                    bad++;
                    $display("FAIL mul_cmd c%0d: got op=%0d a=%0d b=%0d want 0 7 6", c, fu_op, fu_a, fu_b);
                end
            end else begin
                total++;
                if ({busy, result_valid, fu_start} !== 3'b010 || sb.size() == 0) begin
                    bad++;
                    $display("FAIL mul_done_flags: got busy=%b rv=%b start=%b want 0 1 0", busy, result_valid, fu_start);
                end else begin
                    e = sb.pop_front();
                    if (result !== e) begin
                        bad++;
                        $display("FAIL mul_result: got %0d want %0d", result, e);
                    end
                end
            end
            next_cycle();
        end
        fu_done = 1'b0; stall = 1'b0;
        exp_miss = 32'd1;
        total++;
        if ({hit_cnt, miss_cnt} !== {exp_hit, exp_miss}) begin
            bad++;
            $display("FAIL mul_counters: got hit=%0d miss=%0d want %0d %0d", hit_cnt, miss_cnt, exp_hit, exp_miss);
        end
    endtask

    task automatic test_hit_repeat();
        word_t e;
        set_req(1'b1, M_MUL, 32'd7, 32'd6);
        stall = 1'b0;
        sb.push_back(32'd42);
        @(negedge CLK);
        total++;
        if ({busy, result_valid, fu_start} !== 3'b010 || sb.size() == 0) begin
            bad++;
            $display("FAIL hit_flags: got busy=%b rv=%b start=%b want 0 1 0", busy, result_valid, fu_start);
        end else begin
            e = sb.pop_front();
            if (result !== e) begin
                bad++;
                $display("FAIL hit_result: got %0d want %0d", result, e);
            end
        end
        next_cycle();
        req_valid = 1'b0;
        exp_hit = exp_hit + 32'd1;
        total++;
        if ({hit_cnt, miss_cnt} !== {exp_hit, exp_miss}) begin
            bad++;
            $display("FAIL hit_counters: got hit=%0d miss=%0d want %0d %0d", hit_cnt, miss_cnt, exp_hit, exp_miss);
        end
        next_cycle();
    endtask

    // DIV 100/0 squashed at cycle 2, unit finishes at cycle 6. The old MUL
    // entry must still hit afterwards and DIV 100/0 must miss again.
    task automatic test_flush_drain();
        word_t e;
        for (int c = 0; c <= 6; c++) begin
            set_req((c != 4), M_DIV, 32'd100, 32'd0);
            flush   = (c == 2);
            fu_done = (c == 6);
            fu_out  = 32'hFFFF_FFFF;
            @(negedge CLK);
            total++;
            if ({busy, result_valid, fu_start, result} !== {(c != 4), 1'b0, (c == 0), 32'd0}) begin
                bad++;
                $display("FAIL drain c%0d: got busy=%b rv=%b start=%b res=%h want %b 0 %b 0",
                         c, busy, result_valid, fu_start, result, (c != 4), (c == 0));
            end
            next_cycle();
        end
        flush = 1'b0; fu_done = 1'b0;
        exp_miss = exp_miss + 32'd1;
        // Cache must still hold MUL 7,6.
        set_req(1'b1, M_MUL, 32'd7, 32'd6);
        sb.push_back(32'd42);
        @(negedge CLK);
        total++;
        if ({busy, result_valid, fu_start} !== 3'b010 || sb.size() == 0) begin
            bad++;
            $display("FAIL drain_cache_kept: got busy=%b rv=%b start=%b want 0 1 0", busy, result_valid, fu_start);
        end else begin
            e = sb.pop_front();
            if (result !== e) begin
                bad++;
                $display("FAIL drain_cache_value: got %h want %h", result, e);
            end
        end
        next_cycle();
        exp_hit = exp_hit + 32'd1;
        set_req(1'b1, M_DIV, 32'd100, 32'd0);
        sb.push_back(32'hFFFF_FFFF);
        @(negedge CLK);
        total++;
        if ({busy, result_valid, fu_start, fu_op, fu_a, fu_b} !== {3'b101, M_DIV, 32'd100, 32'd0}) begin
            bad++;
            $display("FAIL div_remiss: got busy=%b rv=%b start=%b op=%0d a=%0d b=%0d want 1 0 1 4 100 0",
                     busy, result_valid, fu_start, fu_op, fu_a, fu_b);
        end
        next_cycle();
        exp_miss = exp_miss + 32'd1;
        fu_done = 1'b1; fu_out = 32'hFFFF_FFFF;
        next_cycle();
        fu_done = 1'b0; fu_out = 32'd0; stall = 1'b1;
        @(negedge CLK);
        total++;
        if (result_valid !== 1'b1 || sb.size() == 0) begin
            bad++;
            $display("FAIL div_done_flag: got rv=%b want 1", result_valid);
        end else begin
            e = sb.pop_front();
            if (result !== e) begin
                bad++;
                $display("FAIL div_result: got %h want %h", result, e);
            end
        end
        next_cycle();
        req_valid = 1'b0; stall = 1'b0;
        total++;
        if ({hit_cnt, miss_cnt} !== {exp_hit, exp_miss}) begin
            bad++;
            $display("FAIL drain_counters: got hit=%0d miss=%0d want %0d %0d", hit_cnt, miss_cnt, exp_hit, exp_miss);
        end
    endtask

    task automatic test_reset_mid_run();
        word_t e;
        set_req(1'b1, M_MUL, 32'd3, 32'd4);
        for (int c = 0; c <= 5; c++) begin
            RST       = (c == 3);
            req_valid = (c <= 3);
            fu_done   = (c == 5);
            fu_out    = 32'd12;
            @(negedge CLK);
            if (c >= 3) begin
                total++;
                if ({busy, result_valid, fu_start, result} !== {3'b000, 32'd0}) begin
                    bad++;
                    $display("FAIL rstrun c%0d: got busy=%b rv=%b start=%b res=%h want all 0",
                             c, busy, result_valid, fu_start, result);
                end
            end
            next_cycle();
        end
        RST = 1'b0; fu_done = 1'b0;
        exp_hit = 0; exp_miss = 0;
        total++;
        if ({hit_cnt, miss_cnt} !== 64'd0) begin
            bad++;
            $display("FAIL rstrun_counters: got hit=%0d miss=%0d want 0 0", hit_cnt, miss_cnt);
        end
        // Stale done must not have filled the cache: MUL 3,4 misses.
        set_req(1'b1, M_MUL, 32'd3, 32'd4);
        sb.push_back(32'd12);
        @(negedge CLK);
        total++;
        if ({busy, result_valid, fu_start} !== 3'b101) begin
            bad++;
            $display("FAIL rstrun_remiss: got busy=%b rv=%b start=%b want 1 0 1", busy, result_valid, fu_start);
        end
        next_cycle();
        exp_miss = exp_miss + 32'd1;
        fu_done = 1'b1;
        next_cycle();
        fu_done = 1'b0; stall = 1'b1;
        @(negedge CLK);
        total++;
        if (result_valid !== 1'b1 || sb.size() == 0) begin
            bad++;
            $display("FAIL rstrun_done_flag: got rv=%b want 1", result_valid);
        end else begin
            e = sb.pop_front();
            if (result !== e) begin
                bad++;
                $display("FAIL rstrun_result: got %0d want %0d", result, e);
            end
        end
        next_cycle();
        req_valid = 1'b0; stall = 1'b0;
    endtask

    // Fresh reset, then MUL 5,2 whose rs1 is forwarded to 9 mid-flight.
    task automatic test_forward_change();
        word_t e;
        RST = 1'b1; req_valid = 1'b0; fu_done = 1'b0;
        next_cycle();
        RST = 1'b0;
        next_cycle();
        exp_hit = 0; exp_miss = 0;
        for (int c = 0; c <= 3; c++) begin
            set_req(1'b1, M_MUL, (c == 0) ? 32'd5 : 32'd9, 32'd2);
            fu_done = (c == 3);
            fu_out  = 32'd10;
            @(negedge CLK);
            total++;
            if ({busy, fu_start, fu_a, fu_b} !== {1'b1, (c == 0), 32'd5, 32'd2}) begin
                bad++;
                $display("FAIL fwd_hold c%0d: got busy=%b start=%b a=%0d b=%0d want 1 %b 5 2",
                         c, busy, fu_start, fu_a, fu_b, (c == 0));
            end
            next_cycle();
        end
        exp_miss = exp_miss + 32'd1;
        fu_done = 1'b0;
        sb.push_back(32'd18);
        @(negedge CLK);
        total++;
        if ({busy, result_valid, fu_start, fu_a, result} !== {3'b101, 32'd9, 32'd0}) begin
            bad++;
            $display("FAIL fwd_restart: got busy=%b rv=%b start=%b a=%0d res=%0d want 1 0 1 9 0",
                     busy, result_valid, fu_start, fu_a, result);
        end
        next_cycle();
        exp_miss = exp_miss + 32'd1;
        fu_done = 1'b1; fu_out = 32'd18;
        next_cycle();
        fu_done = 1'b0; stall = 1'b1;
        @(negedge CLK);
        total++;
        if (result_valid !== 1'b1 || sb.size() == 0) begin
            bad++;
            $display("FAIL fwd_done_flag: got rv=%b want 1", result_valid);
        end else begin
            e = sb.pop_front();
            if (result !== e) begin
                bad++;
                $display("FAIL fwd_result: got %0d want %0d", result, e);
            end
        end
        next_cycle();
        total++;
        if ({hit_cnt, miss_cnt} !== {exp_hit, exp_miss}) begin
            bad++;
            $display("FAIL fwd_counters: got hit=%0d miss=%0d want %0d %0d", hit_cnt, miss_cnt, exp_hit, exp_miss);
        end
    endtask

    // Hit on MUL 9,2 held three cycles under stall, then released.
    task automatic test_stall_hold();
        word_t e;
        set_req(1'b1, M_MUL, 32'd9, 32'd2);
        for (int c = 0; c <= 3; c++) begin
            stall = (c != 3);
            sb.push_back(32'd18);
            @(negedge CLK);
            total++;
            if ({busy, result_valid, fu_start} !== 3'b010 || sb.size() == 0) begin
                bad++;
                $display("FAIL stall_flags c%0d: got busy=%b rv=%b start=%b want 0 1 0",
                         c, busy, result_valid, fu_start);
            end else begin
                e = sb.pop_front();
                if (result !== e) begin
                    bad++;
                    $display("FAIL stall_result c%0d: got %0d want %0d", c, result, e);
                end
            end
            next_cycle();
            if (c == 3) exp_hit = exp_hit + 32'd1;
            total++;
            if (hit_cnt !== exp_hit) begin
                bad++;
                $display("FAIL stall_hitcnt c%0d: got %0d want %0d", c, hit_cnt, exp_hit);
            end
        end
        req_valid = 1'b0; stall = 1'b0;
        next_cycle();
    endtask

    initial begin
        RST = 1'b1; stall = 1'b0; flush = 1'b0;
        set_req(1'b0, M_MUL, 32'd0, 32'd0);
        fu_done = 1'b0; fu_out = 32'd0;
        test_reset();
        test_mul_miss();
        test_hit_repeat();
        test_flush_drain();
        test_reset_mid_run();
        test_forward_change();
        test_stall_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
